// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM states, PS/2 set-2 scan-code constants and the set-2 -> HID key map.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_U     = 8'h3C;
    localparam logic [7:0] SC_I     = 8'h43;
    localparam logic [7:0] SC_O     = 8'h44;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_H     = 8'h33;
    localparam logic [7:0] SC_J     = 8'h3B;
    localparam logic [7:0] SC_K     = 8'h42;
    localparam logic [7:0] SC_L     = 8'h4B;

    function automatic logic [7:0] map_key(input logic [7:0] sc);
        case (sc)
            SC_U:    return 8'h18;
            SC_I:    return 8'h0C;
            SC_O:    return 8'h12;
            SC_P:    return 8'h13;
            SC_H:    return 8'h0B;
            SC_J:    return 8'h0D;
            SC_K:    return 8'h0E;
            SC_L:    return 8'h0F;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: synchronises the PS/2 clock and data pins into Clk and flags falling edges of the clock.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic dat_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] cs, ds;
    logic                   prev;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cs   <= '1;
            ds   <= '1;
            prev <= 1'b1;
        end else begin
            cs   <= {cs[SYNC_STAGES-2:0], ps2_clk};
            ds   <= {ds[SYNC_STAGES-2:0], ps2_dat};
            prev <= cs[SYNC_STAGES-1];
        end
    end

    assign dat_s = ds[SYNC_STAGES-1];
    assign fall  = prev & ~cs[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_keycode_gen.sv
// ps2_keycode_gen: PS/2 set-2 receiver producing the held game key as a HID keycode.
// Optional mid-frame idle abort enabled by defining PS2_TIMEOUT_EN.
module ps2_keycode_gen
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] keycode,
    output logic       keycode_valid,
    output logic       parity_err
);

    ps2_state_t state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [7:0] sh, sh_n;
    logic       par, par_n;
    logic       done, done_n;
    logic       ok, ok_n;
    logic       brk, ext;
    logic       dat_s, fall, abort;
    logic [7:0] hid;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .ps2_clk (PS2_CLK),
        .ps2_dat (PS2_DAT),
        .dat_s   (dat_s),
        .fall    (fall)
    );

`ifdef PS2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) to_cnt <= '0;
        else          to_cnt <= (state == IDLE || fall) ? '0 : to_cnt + 1'b1;
    end
    assign abort = state != IDLE && !fall && to_cnt == TW'(TIMEOUT_CYC - 1);
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
            par   <= 1'b0;
            done  <= 1'b0;
            ok    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sh    <= sh_n;
            par   <= par_n;
            done  <= done_n;
            ok    <= ok_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        par_n   = par;
        done_n  = 1'b0;
        ok_n    = ok;
        if (abort) state_n = IDLE;
        else if (fall) begin
            case (state)
                IDLE: begin
                    state_n = dat_s ? IDLE : DATA;
                    cnt_n   = '0;
                end
                DATA: begin
                    sh_n    = {dat_s, sh[7:1]};
                    cnt_n   = cnt + 3'd1;
                    state_n = (cnt == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_n   = dat_s;
                    state_n = STOP;
                end
                STOP: begin
                    done_n  = 1'b1;
                    ok_n    = dat_s & ^{sh, par};
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign hid = map_key(sh);

    // sh is stable in the commit cycle: no new data bit can arrive that soon after STOP
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            keycode       <= 8'h00;
            keycode_valid <= 1'b0;
            parity_err    <= 1'b0;
            brk           <= 1'b0;
            ext           <= 1'b0;
        end else begin
            keycode_valid <= 1'b0;
            parity_err    <= 1'b0;
            if (abort) begin
                brk <= 1'b0;
                ext <= 1'b0;
            end else if (done) begin
                if (!ok) begin
                    parity_err <= 1'b1;
                    brk        <= 1'b0;
                    ext        <= 1'b0;
                end else if (sh == SC_EXT) ext <= 1'b1;
                else if (sh == SC_BREAK) brk <= 1'b1;
                else if (ext) begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end else if (brk) begin
                    if (hid == keycode) keycode <= 8'h00;
                    brk <= 1'b0;
                end else if (hid != 8'h00 && hid != keycode) begin
                    keycode       <= hid;
                    keycode_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_gen.sv
// tb_ps2_keycode_gen: directed PS/2 frame sequences against hand-computed keycodes.
module tb_ps2_keycode_gen;

    logic       Clk = 1'b0;
    logic       Reset_n, PS2_CLK, PS2_DAT;
    logic [7:0] keycode;
    logic       keycode_valid, parity_err;
    int         errs = 0, checks = 0;
    int         vpulses = 0, epulses = 0, v0, e0;

    ps2_keycode_gen #(.SYNC_STAGES(2), .TIMEOUT_CYC(200)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .PS2_CLK       (PS2_CLK),
        .PS2_DAT       (PS2_DAT),
        .keycode       (keycode),
        .keycode_valid (keycode_valid),
        .parity_err    (parity_err)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (keycode_valid === 1'b1) vpulses++;
        if (parity_err === 1'b1) epulses++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic v);
        PS2_DAT = v;
        repeat (10) @(negedge Clk);
        PS2_CLK = 1'b0;
        repeat (10) @(negedge Clk);
        PS2_CLK = 1'b1;
    endtask

    // leaves PS2_CLK low right after the stop-bit falling edge
    task automatic frame_to_stop(input logic [7:0] b, input logic flip, input logic stopv);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ flip);
        PS2_DAT = stopv;
        repeat (10) @(negedge Clk);
        PS2_CLK = 1'b0;
    endtask

    task automatic finish_frame();
        repeat (10) @(negedge Clk);
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        repeat (20) @(negedge Clk);
    endtask

    task automatic send(input logic [7:0] b);
        frame_to_stop(b, 1'b0, 1'b1);
        finish_frame();
    endtask

    initial begin
        Reset_n = 1'b0;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_keycode", keycode, 8'h00);
        chk("rst_valid", keycode_valid, 0);
        chk("rst_perr", parity_err, 0);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);

        v0 = vpulses;
        frame_to_stop(8'h3C, 1'b0, 1'b1);
        repeat (3) @(negedge Clk);
        chk("lat_before", keycode, 8'h00);
        @(negedge Clk);
        chk("lat_after", keycode, 8'h18);
        chk("valid_hi", keycode_valid, 1);
        @(negedge Clk);
        chk("valid_lo", keycode_valid, 0);
        finish_frame();
        chk("make_pulses", vpulses - v0, 1);

        v0 = vpulses;
        send(8'hF0); send(8'h3C);
        chk("release_u", keycode, 8'h00);
        chk("release_pulses", vpulses - v0, 0);

        v0 = vpulses;
        send(8'h3C); send(8'h42);
        chk("last_make", keycode, 8'h0E);
        send(8'hF0); send(8'h3C);
        chk("release_nonheld", keycode, 8'h0E);
        chk("two_make_pulses", vpulses - v0, 2);
        send(8'hF0); send(8'h42);
        chk("release_k", keycode, 8'h00);

        v0 = vpulses; e0 = epulses;
        frame_to_stop(8'h3C, 1'b1, 1'b1);
        finish_frame();
        chk("par_err_pulse", epulses - e0, 1);
        chk("par_err_key", keycode, 8'h00);
        frame_to_stop(8'h3C, 1'b0, 1'b0);
        finish_frame();
        chk("stop_err_pulse", epulses - e0, 2);
        chk("err_no_valid", vpulses - v0, 0);

        send(8'hE0); send(8'h3C);
        chk("ext_ignored", keycode, 8'h00);
        v0 = vpulses;
        send(8'h4B); send(8'h4B); send(8'h4B);
        chk("repeat_key", keycode, 8'h0F);
        chk("repeat_pulses", vpulses - v0, 1);
        send(8'h1C);
        chk("unmapped", keycode, 8'h0F);
        send(8'hE0); send(8'hF0); send(8'h4B);
        chk("ext_break_ignored", keycode, 8'h0F);
        send(8'hF0); send(8'h4B);
        chk("release_l", keycode, 8'h00);

`ifdef PS2_TIMEOUT_EN
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (250) @(negedge Clk);
`endif
        send(8'h33);
        chk("after_partial", keycode, 8'h0B);

        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b0);
        Reset_n = 1'b0;
        @(negedge Clk);
        chk("midrst_keycode", keycode, 8'h00);
        chk("midrst_valid", keycode_valid, 0);
        chk("midrst_perr", parity_err, 0);
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        v0 = vpulses;
        send(8'h4D);
        chk("post_rst_make", keycode, 8'h13);
        chk("post_rst_pulse", vpulses - v0, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
